// File: rtl/sram_arbitrated_gf180.sv
// Banked SRAM with a read/write primary port and a read-only secondary port,
// built from 512x8 GF180 macros with per-bank arbitration and one-cycle read latency.

module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
`ifdef USE_POWER_PINS
   inout  wire        VDD,
   inout  wire        VSS,
`endif
   input  logic       CLK,
   input  logic       CEN,
   input  logic       GWEN,
   input  logic [7:0] WEN,
   input  logic [8:0] A,
   input  logic [7:0] D,
   output logic [7:0] Q
);
   logic [7:0] mem_q [512];

   // Bit-masked write; Q only updates on a read access
   always_ff @(posedge CLK) begin
      if (!CEN) begin
         if (!GWEN) begin
            mem_q[A] <= (mem_q[A] & WEN) | (D & ~WEN);
         end else begin
            Q <= mem_q[A];
         end
      end
   end
endmodule

module sram_arbitrated_gf180 #(
   parameter int BYTE_COUNT   = 4,
   parameter int ADDRESS_SIZE = 10,
   parameter int ROUND_ROBIN  = 1
) (
`ifdef USE_POWER_PINS
   inout  wire                      vccd1,
   inout  wire                      vssd1,
`endif
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      primarySelect,
   input  logic                      primaryWriteEnable,
   input  logic [BYTE_COUNT-1:0]     primaryWriteMask,
   input  logic [ADDRESS_SIZE-1:0]   primaryAddress,
   input  logic [8*BYTE_COUNT-1:0]   primaryDataWrite,
   output logic                      primaryBusy,
   output logic                      primaryReadValid,
   output logic [8*BYTE_COUNT-1:0]   primaryDataRead,
   input  logic                      secondarySelect,
   input  logic [ADDRESS_SIZE-1:0]   secondaryAddress,
   output logic                      secondaryBusy,
   output logic                      secondaryReadValid,
   output logic [8*BYTE_COUNT-1:0]   secondaryDataRead
);
   localparam int WORD_SIZE = 8 * BYTE_COUNT;
   localparam int BANKS     = (ADDRESS_SIZE > 9) ? (1 << (ADDRESS_SIZE - 9)) : 1;
   localparam int BW        = (ADDRESS_SIZE > 9) ? (ADDRESS_SIZE - 9) : 1;

   typedef enum logic {WIN_PRIMARY = 1'b0, WIN_SECONDARY = 1'b1} winner_e;

   logic [BW-1:0]                   pBank_s, sBank_s;
   logic                            conflict_s, primaryWins_s;
   logic                            pGrant_s, sGrant_s;
   winner_e                         lastWinner_q, lastWinner_d;
   logic                            pValid_q, pValid_d, sValid_q, sValid_d;
   logic [BW-1:0]                   pBankQ_q, pBankQ_d, sBankQ_q, sBankQ_d;
   logic [BANKS-1:0][WORD_SIZE-1:0] bankQ_s;

   if (!(BYTE_COUNT == 1 || BYTE_COUNT == 2 || BYTE_COUNT == 4)) begin : g_bad_byte_count
      $error("sram_arbitrated_gf180: BYTE_COUNT must be 1, 2 or 4");
   end
   if (ADDRESS_SIZE < 9) begin : g_bad_address_size
      $error("sram_arbitrated_gf180: ADDRESS_SIZE must be at least 9");
   end

   if (ADDRESS_SIZE > 9) begin : g_multi_bank
      assign pBank_s = primaryAddress[ADDRESS_SIZE-1:9];
      assign sBank_s = secondaryAddress[ADDRESS_SIZE-1:9];
   end else begin : g_single_bank
      assign pBank_s = {BW{1'b0}};
      assign sBank_s = {BW{1'b0}};
   end

   // Grants are forced off while reset is held so Busy mirrors select
   always_comb begin
      conflict_s    = primarySelect & secondarySelect & (pBank_s == sBank_s);
      primaryWins_s = (ROUND_ROBIN == 0) || (lastWinner_q == WIN_SECONDARY);
      pGrant_s      = rst & primarySelect & (~conflict_s | primaryWins_s);
      sGrant_s      = rst & secondarySelect & (~conflict_s | ~primaryWins_s);
      lastWinner_d  = lastWinner_q;
      if (conflict_s) begin
         lastWinner_d = primaryWins_s ? WIN_PRIMARY : WIN_SECONDARY;
      end else begin
         lastWinner_d = lastWinner_q;
      end
      pValid_d = pGrant_s & ~primaryWriteEnable;
      sValid_d = sGrant_s;
      pBankQ_d = pBank_s;
      sBankQ_d = sBank_s;
   end

   assign primaryBusy   = primarySelect & ~pGrant_s;
   assign secondaryBusy = secondarySelect & ~sGrant_s;

   // Arbitration history and read-return tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lastWinner_q <= WIN_SECONDARY;
         pValid_q     <= 1'b0;
         sValid_q     <= 1'b0;
         pBankQ_q     <= {BW{1'b0}};
         sBankQ_q     <= {BW{1'b0}};
      end else begin
         lastWinner_q <= lastWinner_d;
         pValid_q     <= pValid_d;
         sValid_q     <= sValid_d;
         pBankQ_q     <= pBankQ_d;
         sBankQ_q     <= sBankQ_d;
      end
   end

   for (genvar k = 0; k < BANKS; k++) begin : g_bank
      logic       pHit_s, sHit_s, cen_s, gwen_s;
      logic [8:0] row_s;

      assign pHit_s = pGrant_s & (pBank_s == BW'(k));
      assign sHit_s = sGrant_s & (sBank_s == BW'(k));
      assign cen_s  = ~(rst & (pHit_s | sHit_s));
      assign gwen_s = ~(pHit_s & primaryWriteEnable);
      assign row_s  = pHit_s ? primaryAddress[8:0] : secondaryAddress[8:0];

      for (genvar b = 0; b < BYTE_COUNT; b++) begin : g_lane
         gf180mcu_fd_ip_sram__sram512x8m8wm1 u_macro (
`ifdef USE_POWER_PINS
            .VDD  (vccd1),
            .VSS  (vssd1),
`endif
            .CLK  (clk),
            .CEN  (cen_s),
            .GWEN (gwen_s),
            .WEN  ({8{~primaryWriteMask[b]}}),
            .A    (row_s),
            .D    (primaryDataWrite[8*b +: 8]),
            .Q    (bankQ_s[k][8*b +: 8])
         );
      end
   end

   assign primaryReadValid   = pValid_q;
   assign secondaryReadValid = sValid_q;
   assign primaryDataRead    = pValid_q ? bankQ_s[pBankQ_q] : {WORD_SIZE{1'b0}};
   assign secondaryDataRead  = sValid_q ? bankQ_s[sBankQ_q] : {WORD_SIZE{1'b0}};
endmodule
